// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak sizes, FSM states, lane/slice types and layout remaps
package keccak_pkg;

    localparam int LANE_W         = 64;
    localparam int NUM_LANES      = 25;
    localparam int DEF_RATE_LANES = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_ISSUE,
        S_WAIT,
        S_FINAL
    } load_state_t;

    typedef logic [LANE_W-1:0]    lane_t;
    typedef logic [NUM_LANES-1:0] slice_t;
    typedef lane_t  [NUM_LANES-1:0] lanes_t;
    typedef slice_t [LANE_W-1:0]    slices_t;

    // slice i bit (24-j) <-> lane j bit (63-i), identical in both directions
    function automatic slices_t lane2slice(input lanes_t l);
        slices_t s;
        for (int i = 0; i < LANE_W; i++)
            for (int j = 0; j < NUM_LANES; j++)
                s[i][NUM_LANES-1-j] = l[j][LANE_W-1-i];
        return s;
    endfunction

    function automatic lanes_t slice2lane(input slices_t s);
        lanes_t l;
        for (int i = 0; i < LANE_W; i++)
            for (int j = 0; j < NUM_LANES; j++)
                l[j][LANE_W-1-i] = s[i][NUM_LANES-1-j];
        return l;
    endfunction

endpackage

// File: rtl/keccak_absorb_loader_if.sv
// rtl/keccak_absorb_loader_if.sv - message-lane and permutation handshake bundle
interface keccak_absorb_loader_if;
    import keccak_pkg::*;

   logic   in_valid;
   logic   in_ready;
   lane_t  in_data;
   logic   in_last;
   logic   perm_valid;
   logic   perm_ready;
   slice_t state_mat  [0:LANE_W-1];
   logic   perm_done;
   slice_t perm_state [0:LANE_W-1];

   modport master (
      output in_valid, in_data, in_last, perm_ready, perm_done, perm_state,
      input  in_ready, perm_valid, state_mat
   );

   modport slave (
      input  in_valid, in_data, in_last, perm_ready, perm_done, perm_state,
      output in_ready, perm_valid, state_mat
   );

endinterface

// File: rtl/keccak_lane_xor_bank.sv
// rtl/keccak_lane_xor_bank.sv - 25 lane registers with indexed XOR write and full parallel load
module keccak_lane_xor_bank
   import keccak_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       xor_en,
   input  logic [4:0] xor_idx,
   input  lane_t      xor_data,
   input  logic       load_en,
   input  lanes_t     load_data,
   output lanes_t     lanes
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         lanes <= '0;
      end else if (load_en) begin
         lanes <= load_data;
      end else if (xor_en && (xor_idx < 5'(NUM_LANES))) begin
         lanes[xor_idx] <= lanes[xor_idx] ^ xor_data;
      end
   end

endmodule

// File: rtl/keccak_absorb_loader.sv
// rtl/keccak_absorb_loader.sv - absorbs message lanes into the rate, hands blocks to the permutation
module keccak_absorb_loader
   import keccak_pkg::*;
#(
   parameter int RATE_LANES = DEF_RATE_LANES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   keccak_absorb_loader_if.slave   bus,
   output logic                    done,
   output logic                    err
);

   localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

   load_state_t state, state_nx;
   logic [4:0]  lane_idx, lane_idx_nx;
   logic        last_blk, last_blk_nx;
   logic        err_nx, done_nx;
   logic        clear, xor_en, load_en;
   logic        in_ready_c, perm_valid_c;
   lanes_t      lanes;
   slices_t     mat, pstate;

   keccak_lane_xor_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .xor_en    (xor_en),
      .xor_idx   (lane_idx),
      .xor_data  (bus.in_data),
      .load_en   (load_en),
      .load_data (slice2lane(pstate)),
      .lanes     (lanes)
   );

   assign mat = lane2slice(lanes);

   always_comb begin
      for (int i = 0; i < LANE_W; i++) pstate[i] = bus.perm_state[i];
   end

   for (genvar g = 0; g < LANE_W; g++) begin : g_mat
      assign bus.state_mat[g] = mat[g];
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.perm_valid = perm_valid_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         lane_idx <= '0;
         last_blk <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         lane_idx <= lane_idx_nx;
         last_blk <= last_blk_nx;
         err      <= err_nx;
         done     <= done_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      lane_idx_nx  = lane_idx;
      last_blk_nx  = last_blk;
      err_nx       = err;
      done_nx      = 1'b0;
      clear        = 1'b0;
      xor_en       = 1'b0;
      load_en      = 1'b0;
      in_ready_c   = 1'b0;
      perm_valid_c = 1'b0;
      case (state)
         S_IDLE, S_FINAL: begin
            if (start) begin
               clear       = 1'b1;
               lane_idx_nx = '0;
               last_blk_nx = 1'b0;
               err_nx      = 1'b0;
               state_nx    = S_ABSORB;
            end
         end
         S_ABSORB: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               xor_en = 1'b1;
               if (lane_idx == LAST_IDX || bus.in_last) begin
                  // An early in_last leaves the untouched rate lanes as-is (XOR with zero)
                  lane_idx_nx = '0;
                  last_blk_nx = bus.in_last;
                  state_nx    = S_ISSUE;
                  if (bus.in_last && lane_idx != LAST_IDX) err_nx = 1'b1;
               end else begin
                  lane_idx_nx = lane_idx + 5'd1;
               end
            end
         end
         S_ISSUE: begin
            perm_valid_c = 1'b1;
            if (bus.perm_ready) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (bus.perm_done) begin
               load_en = 1'b1;
               if (last_blk) begin
                  state_nx = S_FINAL;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = S_ABSORB;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_keccak_absorb_loader.sv
// tb/tb_keccak_absorb_loader.sv - directed self-checking bench for keccak_absorb_loader
module tb_keccak_absorb_loader;

   logic clk = 1'b0;
   logic rst, start, done, err;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] exp_l [25];
   logic [63:0] ps    [25];

   keccak_absorb_loader_if bus ();

   keccak_absorb_loader dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus.slave),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_mat(input string tag);
      logic [1599:0] obs_all, exp_all;
      int bad;
      bad = -1;
      for (int j = 0; j < 25; j++) begin
         for (int i = 0; i < 64; i++) obs_all[j*64 + (63-i)] = bus.state_mat[i][24-j];
         exp_all[j*64 +: 64] = exp_l[j];
         if (bad < 0 && obs_all[j*64 +: 64] !== exp_l[j]) bad = j;
      end
      checks++;
      assert (obs_all === exp_all) else begin
         errors++;
         $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad,
                obs_all[bad*64 +: 64], exp_l[bad]);
      end
   endtask

   task automatic drive_pstate();
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 25; j++)
            bus.perm_state[i][24-j] = ps[j][63-i];
   endtask

   task automatic send(input logic [63:0] d, input logic last);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic set_exp(input logic [63:0] v);
      for (int j = 0; j < 25; j++) exp_l[j] = v;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      bus.perm_ready = 1'b0; bus.perm_done = 1'b0;
      set_exp('0);
      for (int j = 0; j < 25; j++) ps[j] = '0;
      drive_pstate();
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 0);
      chk("rst_perm_valid", 64'(bus.perm_valid), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);
      chk_mat("rst_mat");

      // 1: reset in the middle of absorbing
      tick(); start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 5; k++) send(64'hAA00 + 64'(k), 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus.in_ready), 0);
      chk("midrst_err", 64'(err), 0);
      chk_mat("midrst_mat");

      // 2: single full block, words 1..17
      tick(); start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 17; k++) send(64'(k), k == 17);
      @(negedge clk);
      chk("blk1_perm_valid", 64'(bus.perm_valid), 1);
      chk("blk1_in_ready", 64'(bus.in_ready), 0);
      chk("blk1_err", 64'(err), 0);
      set_exp('0);
      for (int j = 0; j < 17; j++) exp_l[j] = 64'(j + 1);
      chk_mat("blk1_mat");
      chk("blk1_s63b24", 64'(bus.state_mat[63][24]), 1);

      // 3: backpressure from the permutation
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         chk("hold_perm_valid", 64'(bus.perm_valid), 1);
         chk("hold_in_ready", 64'(bus.in_ready), 0);
         chk_mat("hold_mat");
      end
      tick(); bus.perm_ready = 1'b1; tick(); bus.perm_ready = 1'b0;
      @(negedge clk);
      chk("wait_perm_valid", 64'(bus.perm_valid), 0);
      for (int j = 0; j < 25; j++) ps[j] = 64'h0123_4567_89AB_CDEF ^ (64'(j) * 64'h1111);
      drive_pstate();
      tick(); bus.perm_done = 1'b1; tick(); bus.perm_done = 1'b0;
      @(negedge clk);
      chk("fin1_done", 64'(done), 1);
      chk("fin1_in_ready", 64'(bus.in_ready), 0);
      for (int j = 0; j < 25; j++) exp_l[j] = ps[j];
      chk_mat("fin1_mat");
      tick();
      @(negedge clk);
      chk("fin1_done_pulse", 64'(done), 0);

      // 4: start from FINAL, two-block message
      tick(); start = 1'b1; tick(); start = 1'b0;
      @(negedge clk);
      set_exp('0);
      chk_mat("restart_mat");
      chk("restart_in_ready", 64'(bus.in_ready), 1);
      tick();
      for (int k = 0; k < 17; k++) send(64'hDEAD_0000 + 64'(k), 1'b0);
      @(negedge clk);
      chk("blk2a_perm_valid", 64'(bus.perm_valid), 1);
      tick(); bus.perm_ready = 1'b1; tick(); bus.perm_ready = 1'b0;
      for (int j = 0; j < 25; j++) ps[j] = '1;
      drive_pstate();
      bus.perm_done = 1'b1; tick(); bus.perm_done = 1'b0;
      @(negedge clk);
      chk("blk2b_in_ready", 64'(bus.in_ready), 1);
      chk("blk2b_done", 64'(done), 0);
      set_exp('1);
      chk_mat("blk2b_load");
      tick();
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(negedge clk);
      exp_l[0] = '0;
      chk_mat("blk2b_lane0");

      // 5: early in_last on word 3
      tick();
      send(64'h1234, 1'b0);
      send(64'hF, 1'b1);
      @(negedge clk);
      exp_l[1] = 64'hFFFF_FFFF_FFFF_EDCB;
      exp_l[2] = 64'hFFFF_FFFF_FFFF_FFF0;
      chk("early_err", 64'(err), 1);
      chk("early_perm_valid", 64'(bus.perm_valid), 1);
      chk_mat("early_mat");

      // 6: final permutation, stray perm_done, restart
      tick(); bus.perm_ready = 1'b1; tick(); bus.perm_ready = 1'b0;
      for (int j = 0; j < 25; j++) ps[j] = {32'hC0DE_0000 + 32'(j), 32'h5A5A_A5A5};
      drive_pstate();
      bus.perm_done = 1'b1; tick(); bus.perm_done = 1'b0;
      @(negedge clk);
      chk("fin2_done", 64'(done), 1);
      chk("fin2_err_sticky", 64'(err), 1);
      for (int j = 0; j < 25; j++) exp_l[j] = ps[j];
      chk_mat("fin2_mat");
      tick();
      @(negedge clk);
      chk("fin2_done_pulse", 64'(done), 0);
      for (int j = 0; j < 25; j++) ps[j] = '0;
      tick(); drive_pstate(); bus.perm_done = 1'b1; tick(); bus.perm_done = 1'b0;
      @(negedge clk);
      chk("stray_done", 64'(done), 0);
      chk("stray_perm_valid", 64'(bus.perm_valid), 0);
      chk_mat("stray_mat");
      tick(); start = 1'b1; tick(); start = 1'b0;
      @(negedge clk);
      set_exp('0);
      chk_mat("restart2_mat");
      chk("restart2_err", 64'(err), 0);
      chk("restart2_in_ready", 64'(bus.in_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
